// File: rtl/pathfinding_pkg.sv
// ============================================================================
// Package  : pathfinding_pkg
// Purpose  : Shared node_info record type, sizes and fetch FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pathfinding_pkg;

    localparam int NODE_WORDS_C = 17;
    localparam int NODE_BITS_C  = NODE_WORDS_C * 16;

    typedef logic [NODE_BITS_C-1:0] node_info;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/node_fetch_arbiter_if.sv
// ============================================================================
// Interface : node_fetch_arbiter_if
// Purpose   : Requester handshake, node memory read port and response bus.
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface node_fetch_arbiter_if #(
    parameter int ADDR_W     = 10,
    parameter int NODE_WORDS = pathfinding_pkg::NODE_WORDS_C
);
    logic [1:0]               req_valid;
    logic [1:0][7:0]          req_slot;
    logic [1:0]               req_ready;
    logic [ADDR_W-1:0]        mem_address;
    logic                     mem_read;
    logic [15:0]              mem_readdata;
    logic                     resp_valid;
    logic                     resp_id;
    logic [NODE_WORDS*16-1:0] resp_data;
    logic                     busy;

    // The arbiter side drives memory and responses.
    modport master (
        input  req_valid, req_slot, mem_readdata,
        output req_ready, mem_address, mem_read, resp_valid, resp_id, resp_data, busy
    );

    modport slave (
        output req_valid, req_slot, mem_readdata,
        input  req_ready, mem_address, mem_read, resp_valid, resp_id, resp_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin grant; requester 0 wins the first contention.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic [1:0] req,
    input  wire logic       advance,
    output logic      [1:0] gnt
);
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && (gnt != 2'b00)) begin
            last_grant_d = gnt[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/node_fetch_arbiter.sv
// ============================================================================
// Module   : node_fetch_arbiter
// Purpose  : Shares the node memory read port between two requesters and
//            assembles NODE_WORDS 16-bit words into one node_info record.
//            Optional NODE_FETCH_PERF_EN adds grant/contention counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module node_fetch_arbiter
    import pathfinding_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int NODE_WORDS = NODE_WORDS_C,
    parameter int RD_LAT     = 1
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    node_fetch_arbiter_if.master bus
`ifdef NODE_FETCH_PERF_EN
    ,
    output logic [15:0]         grant_cnt0,
    output logic [15:0]         grant_cnt1,
    output logic [15:0]         contend_cnt
`endif
);
    localparam int            KW     = (NODE_WORDS > 1) ? $clog2(NODE_WORDS) : 1;
    localparam int            DW     = NODE_WORDS * 16;
    localparam logic [KW-1:0] K_LAST = KW'(NODE_WORDS - 1);

    fetch_state_t      state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              id_q, id_d;
    logic              rv_q, rv_d;
    logic [DW-1:0]     data_q, data_d;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [KW-1:0]     pipe_tag_q [RD_LAT];
    logic [KW-1:0]     pipe_tag_d [RD_LAT];

    logic [1:0]        w_gnt;
    logic [1:0]        w_ready;
    logic              w_advance;
    logic [7:0]        w_slot;
    logic [ADDR_W-1:0] w_base;
    logic              w_last_cap;

    assign w_advance = (state_q == IDLE) && (bus.req_valid != 2'b00);
    assign w_ready   = (state_q == IDLE) ? w_gnt : 2'b00;
    assign w_slot    = w_gnt[1] ? bus.req_slot[1] : bus.req_slot[0];
    // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap of the base address.
    assign w_base    = ADDR_W'(32'(w_slot) * 32'(NODE_WORDS));
    assign w_last_cap = pipe_vld_q[RD_LAT-1] && (pipe_tag_q[RD_LAT-1] == K_LAST);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .advance (w_advance),
        .gnt     (w_gnt)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        id_d    = id_q;
        rv_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_advance) begin
                    state_d = ISSUE;
                    addr_d  = w_base;
                    k_d     = '0;
                    rd_d    = 1'b1;
                    id_d    = w_gnt[1];
                end
            end
            ISSUE: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d    = k_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                    rd_d   = 1'b1;
                end
            end
            DRAIN: begin
                if (w_last_cap) begin
                    state_d = RESP;
                    rv_d    = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Each issued read carries its word index down the latency pipe.
    always_comb begin
        pipe_vld_d[0] = rd_q;
        pipe_tag_d[0] = k_q;
        for (int j = 1; j < RD_LAT; j++) begin
            pipe_vld_d[j] = pipe_vld_q[j-1];
            pipe_tag_d[j] = pipe_tag_q[j-1];
        end
    end

    always_comb begin
        data_d = data_q;
        if (pipe_vld_q[RD_LAT-1]) begin
            for (int w = 0; w < NODE_WORDS; w++) begin
                if (pipe_tag_q[RD_LAT-1] == KW'(w)) begin
                    data_d[DW-1-16*w -: 16] = bus.mem_readdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            id_q       <= 1'b0;
            rv_q       <= 1'b0;
            data_q     <= '0;
            pipe_vld_q <= '0;
            for (int j = 0; j < RD_LAT; j++) begin
                pipe_tag_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            id_q       <= id_d;
            rv_q       <= rv_d;
            data_q     <= data_d;
            pipe_vld_q <= pipe_vld_d;
            for (int j = 0; j < RD_LAT; j++) begin
                pipe_tag_q[j] <= pipe_tag_d[j];
            end
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.mem_address = addr_q;
    assign bus.mem_read    = rd_q;
    assign bus.resp_valid  = rv_q;
    assign bus.resp_id     = id_q;
    assign bus.resp_data   = data_q;
    assign bus.busy        = (state_q != IDLE);

`ifdef NODE_FETCH_PERF_EN
    logic [15:0] gc0_q, gc0_d;
    logic [15:0] gc1_q, gc1_d;
    logic [15:0] cc_q, cc_d;

    always_comb begin
        gc0_d = gc0_q;
        gc1_d = gc1_q;
        cc_d  = cc_q;
        if (w_ready[0] && (gc0_q != 16'hFFFF)) gc0_d = gc0_q + 16'd1;
        if (w_ready[1] && (gc1_q != 16'hFFFF)) gc1_d = gc1_q + 16'd1;
        if ((state_q == IDLE) && (bus.req_valid == 2'b11) && (cc_q != 16'hFFFF)) begin
            cc_d = cc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gc0_q <= '0;
            gc1_q <= '0;
            cc_q  <= '0;
        end else begin
            gc0_q <= gc0_d;
            gc1_q <= gc1_d;
            cc_q  <= cc_d;
        end
    end

    assign grant_cnt0  = gc0_q;
    assign grant_cnt1  = gc1_q;
    assign contend_cnt = cc_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_node_fetch_arbiter.sv
// ============================================================================
// Module   : tb_node_fetch_arbiter
// Purpose  : Self-checking bench; three DUTs cover RD_LAT 1/2/3 and a 6-bit
//            address wrap against a record-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_node_fetch_arbiter;
    import pathfinding_pkg::*;

    localparam int N_INST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N_INST-1:0] rst_n;
    logic [1:0]        req_valid [N_INST];
    logic [1:0][7:0]   req_slot  [N_INST];
    wire  [1:0]        req_ready   [N_INST];
    wire  [9:0]        mem_address [N_INST];
    wire               mem_read    [N_INST];
    wire               resp_valid  [N_INST];
    wire               resp_id     [N_INST];
    wire  [271:0]      resp_data   [N_INST];
    wire               busy        [N_INST];
    logic [15:0]       mem [N_INST][1024];
`ifdef NODE_FETCH_PERF_EN
    wire  [15:0]       gc0 [N_INST];
    wire  [15:0]       gc1 [N_INST];
    wire  [15:0]       cc  [N_INST];
`endif

    int n_vec = 0;
    int n_err = 0;

    function automatic int lat_of(input int i);
        return i + 1;
    endfunction

    function automatic int aw_of(input int i);
        return (i == 2) ? 6 : 10;
    endfunction

    generate
        for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
            localparam int AW  = (gi == 2) ? 6 : 10;
            localparam int LAT = gi + 1;
            node_fetch_arbiter_if #(.ADDR_W(AW)) ifc ();
            logic [AW-1:0] ad [LAT];

            assign ifc.req_valid     = req_valid[gi];
            assign ifc.req_slot      = req_slot[gi];
            assign ifc.mem_readdata  = mem[gi][10'(ad[LAT-1])];
            assign req_ready[gi]     = ifc.req_ready;
            assign mem_address[gi]   = 10'(ifc.mem_address);
            assign mem_read[gi]      = ifc.mem_read;
            assign resp_valid[gi]    = ifc.resp_valid;
            assign resp_id[gi]       = ifc.resp_id;
            assign resp_data[gi]     = ifc.resp_data;
            assign busy[gi]          = ifc.busy;

            // Memory returns the addressed word LAT cycles after the address.
            always @(posedge clk) begin
                ad[0] <= ifc.mem_address;
                for (int j = 1; j < LAT; j++) ad[j] <= ad[j-1];
            end

            node_fetch_arbiter #(.ADDR_W(AW), .NODE_WORDS(17), .RD_LAT(LAT)) u_dut (
                .clk     (clk),
                .reset_n (rst_n[gi]),
                .bus     (ifc)
`ifdef NODE_FETCH_PERF_EN
                ,
                .grant_cnt0  (gc0[gi]),
                .grant_cnt1  (gc1[gi]),
                .contend_cnt (cc[gi])
`endif
            );
        end
    endgenerate

    function automatic logic [9:0] exp_addr(input int i, input int slot, input int k);
        int m = 1 << aw_of(i);
        return 10'(((slot * 17) + k) % m);
    endfunction

    function automatic logic [271:0] exp_data(input int i, input int slot);
        logic [271:0] d = '0;
        for (int k = 0; k < 17; k++) d[271-16*k -: 16] = mem[i][exp_addr(i, slot, k)];
        return d;
    endfunction

    // Observation of one grant and its response; comparisons live in the tests.
    int           obs_wait, obs_lat, obs_ready_busy;
    logic [1:0]   obs_gnt;
    logic         obs_id;
    logic [271:0] obs_data;
    logic [9:0]   obs_addr [$];

    task automatic observe(input int i, input bit drop, input int raise_at, input logic [1:0] raise_mask);
        obs_wait = 0; obs_lat = -1; obs_ready_busy = 0; obs_gnt = 2'b00;
        obs_id = 1'bx; obs_data = 'x; obs_addr.delete();
        #1;
        while (req_ready[i] == 2'b00 && obs_wait < 100) begin
            @(negedge clk); #1; obs_wait++;
        end
        if (req_ready[i] == 2'b00) return;
        obs_gnt = req_ready[i];
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1 && drop) req_valid[i] = req_valid[i] & ~obs_gnt;
            if (n == raise_at) req_valid[i] = req_valid[i] | raise_mask;
            #1;
            if (mem_read[i]) obs_addr.push_back(mem_address[i]);
            if (req_ready[i] != 2'b00) obs_ready_busy++;
            if (resp_valid[i]) begin
                obs_lat = n; obs_id = resp_id[i]; obs_data = resp_data[i];
                break;
            end
        end
    endtask

    task automatic apply_reset(input int i);
        rst_n[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[i] = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (req_ready[0] !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b want=00", req_ready[0]); end
        n_vec++; if (mem_read[0] !== 1'b0) begin n_err++; $display("FAIL reset_mem_read got=%b want=0", mem_read[0]); end
        n_vec++; if (mem_address[0] !== 10'd0) begin n_err++; $display("FAIL reset_addr got=%0d want=0", mem_address[0]); end
        n_vec++; if (resp_valid[0] !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid[0]); end
        n_vec++; if (resp_id[0] !== 1'b0) begin n_err++; $display("FAIL reset_resp_id got=%b want=0", resp_id[0]); end
        n_vec++; if (resp_data[0] !== 272'd0) begin n_err++; $display("FAIL reset_resp_data got=%h want=0", resp_data[0]); end
        n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy[0]); end
        @(negedge clk);
        rst_n = '1;
    endtask

    task automatic test_single;
        for (int a = 0; a < 1024; a++) mem[0][a] = 16'(a);
        @(negedge clk);
        req_slot[0][0] = 8'd2;
        req_valid[0] = 2'b01;
        observe(0, 1'b1, 0, 2'b00);
        n_vec++; if (obs_gnt !== 2'b01) begin n_err++; $display("FAIL single_grant got=%b want=01", obs_gnt); end
        n_vec++; if (obs_addr.size() !== 17) begin n_err++; $display("FAIL single_addr_count got=%0d want=17", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 17; k++) begin
            n_vec++; if (obs_addr[k] !== 10'(34 + k)) begin n_err++; $display("FAIL single_addr[%0d] got=%0d want=%0d", k, obs_addr[k], 34 + k); end
        end
        n_vec++; if (obs_lat !== 19) begin n_err++; $display("FAIL single_latency got=%0d want=19", obs_lat); end
        n_vec++; if (obs_id !== 1'b0) begin n_err++; $display("FAIL single_resp_id got=%b want=0", obs_id); end
        n_vec++; if (obs_data[271:256] !== 16'd34) begin n_err++; $display("FAIL single_word0 got=%0d want=34", obs_data[271:256]); end
        n_vec++; if (obs_data[15:0] !== 16'd50) begin n_err++; $display("FAIL single_word16 got=%0d want=50", obs_data[15:0]); end
        n_vec++; if (obs_data !== exp_data(0, 2)) begin n_err++; $display("FAIL single_record got=%h want=%h", obs_data, exp_data(0, 2)); end
        @(negedge clk); #1;
        n_vec++; if (resp_valid[0] !== 1'b0) begin n_err++; $display("FAIL single_pulse got=%b want=0", resp_valid[0]); end
        n_vec++; if (resp_data[0] !== exp_data(0, 2)) begin n_err++; $display("FAIL single_hold got=%h want=%h", resp_data[0], exp_data(0, 2)); end
    endtask

    task automatic test_contention;
        int s [2];
        int last = 1;
        int want;
        for (int a = 0; a < 1024; a++) mem[0][a] = 16'($urandom);
        s[0] = int'($urandom_range(0, 255));
        s[1] = int'($urandom_range(0, 255));
        req_slot[0][0] = 8'(s[0]);
        req_slot[0][1] = 8'(s[1]);
        req_valid[0] = 2'b11;
        apply_reset(0);
        for (int g = 0; g < 4; g++) begin
            want = (last == 1) ? 0 : 1;
            last = want;
            observe(0, 1'b0, 0, 2'b00);
            n_vec++; if (obs_gnt !== 2'(1 << want)) begin n_err++; $display("FAIL contend_grant[%0d] got=%b want=%0d", g, obs_gnt, want); end
            n_vec++; if (obs_id !== 1'(want)) begin n_err++; $display("FAIL contend_id[%0d] got=%b want=%0d", g, obs_id, want); end
            n_vec++; if (obs_data !== exp_data(0, s[want])) begin n_err++; $display("FAIL contend_record[%0d] got=%h want=%h", g, obs_data, exp_data(0, s[want])); end
            n_vec++; if (obs_lat !== 19) begin n_err++; $display("FAIL contend_latency[%0d] got=%0d want=19", g, obs_lat); end
            if (g > 0) begin
                n_vec++; if (obs_wait !== 1) begin n_err++; $display("FAIL contend_gap[%0d] got=%0d want=1", g, obs_wait); end
            end
`ifdef NODE_FETCH_PERF_EN
            if (g == 1) begin
                n_vec++; if (cc[0] !== 16'd2) begin n_err++; $display("FAIL contend_cnt got=%0d want=2", cc[0]); end
            end
`endif
        end
        req_valid[0] = 2'b00;
`ifdef NODE_FETCH_PERF_EN
        n_vec++; if (gc0[0] !== 16'd2 || gc1[0] !== 16'd2) begin n_err++; $display("FAIL grant_cnt got=%0d/%0d want=2/2", gc0[0], gc1[0]); end
`endif
    endtask

    task automatic test_late;
        int s0 = int'($urandom_range(0, 255));
        int s1 = int'($urandom_range(0, 255));
        @(negedge clk);
        req_slot[0][0] = 8'(s0);
        req_slot[0][1] = 8'(s1);
        req_valid[0] = 2'b01;
        observe(0, 1'b1, 5, 2'b10);
        n_vec++; if (obs_gnt !== 2'b01) begin n_err++; $display("FAIL late_first_grant got=%b want=01", obs_gnt); end
        n_vec++; if (obs_ready_busy !== 0) begin n_err++; $display("FAIL late_ready_busy got=%0d want=0", obs_ready_busy); end
        n_vec++; if (obs_data !== exp_data(0, s0)) begin n_err++; $display("FAIL late_first_record got=%h want=%h", obs_data, exp_data(0, s0)); end
        observe(0, 1'b1, 0, 2'b00);
        n_vec++; if (obs_wait !== 1) begin n_err++; $display("FAIL late_grant_delay got=%0d want=1", obs_wait); end
        n_vec++; if (obs_gnt !== 2'b10) begin n_err++; $display("FAIL late_second_grant got=%b want=10", obs_gnt); end
        n_vec++; if (obs_id !== 1'b1) begin n_err++; $display("FAIL late_resp_id got=%b want=1", obs_id); end
        n_vec++; if (obs_data !== exp_data(0, s1)) begin n_err++; $display("FAIL late_second_record got=%h want=%h", obs_data, exp_data(0, s1)); end
    endtask

    task automatic test_latency;
        int r, s;
        bit addr_ok;
        for (int i = 0; i < N_INST; i++) begin
            for (int a = 0; a < 1024; a++) mem[i][a] = 16'($urandom);
            for (int it = 0; it < 4; it++) begin
                r = int'($urandom_range(0, 1));
                s = int'($urandom_range(0, 255));
                @(negedge clk);
                req_slot[i][r] = 8'(s);
                req_valid[i] = 2'(1 << r);
                observe(i, 1'b1, 0, 2'b00);
                addr_ok = (obs_addr.size() == 17);
                for (int k = 0; k < obs_addr.size() && k < 17; k++)
                    if (obs_addr[k] !== exp_addr(i, s, k)) addr_ok = 1'b0;
                n_vec++; if (obs_gnt !== 2'(1 << r)) begin n_err++; $display("FAIL lat%0d_grant got=%b want=%0d", lat_of(i), obs_gnt, r); end
                n_vec++; if (obs_lat !== 18 + lat_of(i)) begin n_err++; $display("FAIL lat%0d_latency got=%0d want=%0d", lat_of(i), obs_lat, 18 + lat_of(i)); end
                n_vec++; if (addr_ok !== 1'b1) begin n_err++; $display("FAIL lat%0d_addresses got=%0d words want=17 matching slot %0d", lat_of(i), obs_addr.size(), s); end
                n_vec++; if (obs_id !== 1'(r)) begin n_err++; $display("FAIL lat%0d_id got=%b want=%0d", lat_of(i), obs_id, r); end
                n_vec++; if (obs_data !== exp_data(i, s)) begin n_err++; $display("FAIL lat%0d_record got=%h want=%h", lat_of(i), obs_data, exp_data(i, s)); end
            end
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        req_slot[2][0] = 8'd4;
        req_valid[2] = 2'b01;
        observe(2, 1'b1, 0, 2'b00);
        n_vec++; if (obs_addr.size() !== 17) begin n_err++; $display("FAIL wrap_count got=%0d want=17", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 17; k++) begin
            n_vec++; if (obs_addr[k] !== 10'(4 + k)) begin n_err++; $display("FAIL wrap_addr[%0d] got=%0d want=%0d", k, obs_addr[k], 4 + k); end
        end
        n_vec++; if (obs_data !== exp_data(2, 4)) begin n_err++; $display("FAIL wrap_record got=%h want=%h", obs_data, exp_data(2, 4)); end
    endtask

    task automatic test_reset_abort;
        int s = int'($urandom_range(0, 255));
        int seen_resp = 0;
        bit found = 1'b0;
        @(negedge clk);
        req_slot[0][0] = 8'(s);
        req_valid[0] = 2'b01;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (n == 0) req_valid[0] = 2'b00;
            #1;
            if (mem_read[0] && mem_address[0] == exp_addr(0, s, 9)) found = 1'b1;
        end
        n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL abort_word9 got=not_seen want=seen"); end
        rst_n[0] = 1'b0;
        #1;
        n_vec++; if (busy[0] !== 1'b0 || mem_read[0] !== 1'b0 || mem_address[0] !== 10'd0) begin
            n_err++; $display("FAIL abort_outputs got=busy%b rd%b addr%0d want=0/0/0", busy[0], mem_read[0], mem_address[0]); end
        n_vec++; if (resp_data[0] !== 272'd0 || resp_id[0] !== 1'b0 || req_ready[0] !== 2'b00) begin
            n_err++; $display("FAIL abort_resp got=id%b ready%b data%h want=zero", resp_id[0], req_ready[0], resp_data[0]); end
        for (int n = 0; n < 8; n++) begin
            if (n == 3) rst_n[0] = 1'b1;
            @(negedge clk); #1;
            if (resp_valid[0] !== 1'b0) seen_resp++;
        end
        n_vec++; if (seen_resp !== 0) begin n_err++; $display("FAIL abort_no_resp got=%0d pulses want=0", seen_resp); end
        s = int'($urandom_range(0, 255));
        req_slot[0][0] = 8'(s);
        req_valid[0] = 2'b01;
        observe(0, 1'b1, 0, 2'b00);
        n_vec++; if (obs_gnt !== 2'b01) begin n_err++; $display("FAIL abort_regrant got=%b want=01", obs_gnt); end
        n_vec++; if (obs_lat !== 19) begin n_err++; $display("FAIL abort_latency got=%0d want=19", obs_lat); end
        n_vec++; if (obs_data !== exp_data(0, s)) begin n_err++; $display("FAIL abort_record got=%h want=%h", obs_data, exp_data(0, s)); end
    endtask

    initial begin
        rst_n = '0;
        for (int i = 0; i < N_INST; i++) begin
            req_valid[i] = 2'b00;
            req_slot[i]  = '0;
            for (int a = 0; a < 1024; a++) mem[i][a] = 16'($urandom);
        end
        test_reset;
        test_single;
        test_contention;
        test_late;
        test_latency;
        test_wrap;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule

`default_nettype wire
